weight_loader: RTL and testbench



---
 rtl/weight_loader.sv | 105 ++++++++++
 tb/tb_weight_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Weight/bias SRAM front-end: packs a byte stream into 72-bit words, writes them from
// address 0 upward, then raises sta to hand the SRAM over to the read-out sequence.
module weight_loader #(
  parameter int NUM_WORDS  = 545,
  parameter int WORD_BYTES = 9,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    write_en,
  output logic [8*WORD_BYTES-1:0] data_w,
  output logic [ADDR_W-1:0]       addr_w,
  output logic                    sta,
  output logic                    load_done,
  output logic                    busy
);

  localparam int                 CNT_W     = $clog2(WORD_BYTES + 1);
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [8*WORD_BYTES-1:0] data_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    ready_q;
  logic                    we_q;
  logic                    sta_q;
  logic                    done_q;
  logic                    busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      sta_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        // A new load may begin from idle or as a reload after a finished one.
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            sta_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (cnt_q == CNT_W'(k)) data_q[8*k +: 8] <= byte_in;
            end
            if (cnt_q == LAST_BYTE) begin
              cnt_q   <= '0;
              state_q <= WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        // Single write cycle; sta only rises after write_en has dropped.
        WRITE: begin
          we_q <= 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_q <= DONE;
            sta_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= LOAD;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign write_en   = we_q;
  assign data_w     = data_q;
  assign addr_w     = addr_q;
  assign sta        = sta_q;
  assign load_done  = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: three instances (1, 2 and 545 words) driven with random
// byte streams; expected SRAM words are built directly from the sent byte list.
module tb_weight_loader;
  localparam int NI = 3;
  localparam int FULL_WORDS = 545;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [NI];
  logic       valid_s [NI];
  logic [7:0] byte_s  [NI];
  logic       ready_o [NI];
  logic       we_o    [NI];
  logic       sta_o   [NI];
  logic       ld_o    [NI];
  logic       busy_o  [NI];
  logic [71:0] data_o [NI];
  logic [9:0]  addr_o [NI];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int inst; logic [9:0] a; logic [71:0] d; int c; } wr_t;
  wr_t        wrs[$];
  logic [7:0] tx[$];
  int         sta_rise [NI];
  logic       sta_prev [NI];

  weight_loader #(.NUM_WORDS(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .byte_in(byte_s[0]), .byte_valid(valid_s[0]),
    .byte_ready(ready_o[0]), .write_en(we_o[0]), .data_w(data_o[0]), .addr_w(addr_o[0]),
    .sta(sta_o[0]), .load_done(ld_o[0]), .busy(busy_o[0]));

  weight_loader #(.NUM_WORDS(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .byte_in(byte_s[1]), .byte_valid(valid_s[1]),
    .byte_ready(ready_o[1]), .write_en(we_o[1]), .data_w(data_o[1]), .addr_w(addr_o[1]),
    .sta(sta_o[1]), .load_done(ld_o[1]), .busy(busy_o[1]));

  weight_loader u_full (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .byte_in(byte_s[2]), .byte_valid(valid_s[2]),
    .byte_ready(ready_o[2]), .write_en(we_o[2]), .data_w(data_o[2]), .addr_w(addr_o[2]),
    .sta(sta_o[2]), .load_done(ld_o[2]), .busy(busy_o[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write logger: every SRAM write is recorded, and the write cycle must exclude sta/byte_ready.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (we_o[i] === 1'b1) begin
        wrs.push_back('{inst: i, a: addr_o[i], d: data_o[i], c: cyc});
        checks++;
        if (sta_o[i] !== 1'b0 || ready_o[i] !== 1'b0) begin
          errors++;
          $display("FAIL write_excl inst%0d: sta=%b byte_ready=%b with write_en, required 0 0",
                   i, sta_o[i], ready_o[i]);
        end
      end
      if (sta_o[i] === 1'b1 && sta_prev[i] !== 1'b1) sta_rise[i] = cyc;
      sta_prev[i] = sta_o[i];
    end
  end

  function automatic logic [71:0] word_of(input int j);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = tx[9*j + k];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    step();
    start_s[i] = 1'b0;
  endtask

  // Offers tx[lo..hi-1]; a byte counts as taken when valid and byte_ready met at an edge.
  task automatic send(input int i, input int lo, input int hi, input bit gaps);
    int   idx;
    int   guard;
    logic r;
    logic v;
    idx = lo;
    guard = 0;
    while (idx < hi && guard < (hi - lo) * 8 + 50) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      valid_s[i] = v;
      byte_s[i] = tx[idx];
      @(negedge clk);
      r = ready_o[i];
      step();
      if (v && r) idx++;
      guard++;
    end
    valid_s[i] = 1'b0;
    checks++;
    if (idx < hi) begin
      errors++;
      $display("FAIL send_timeout inst%0d: accepted %0d bytes, required %0d", i, idx - lo, hi - lo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      valid_s[i] = 1'b1;
      byte_s[i] = 8'($urandom);
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({ready_o[i], we_o[i], sta_o[i], ld_o[i], busy_o[i]} !== 5'b0 ||
            data_o[i] !== 72'h0 || addr_o[i] !== 10'h0) begin
          errors++;
          $display("FAIL reset_idle inst%0d cyc%0d: rdy/we/sta/ld/busy=%b data=%h addr=%0d, required all 0",
                   i, n, {ready_o[i], we_o[i], sta_o[i], ld_o[i], busy_o[i]}, data_o[i], addr_o[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) valid_s[i] = 1'b0;
  endtask

  task automatic test_single();
    int n;
    tx.delete();
    for (int k = 1; k <= 9; k++) tx.push_back(8'(k));
    pulse_start(0);
    checks++;
    if (busy_o[0] !== 1'b1 || ready_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_load busy=%b byte_ready=%b, required 1 1", busy_o[0], ready_o[0]);
    end
    send(0, 0, 9, 1'b0);
    checks++;
    if (we_o[0] !== 1'b1 || addr_o[0] !== 10'd0 || data_o[0] !== word_of(0)) begin
      errors++;
      $display("FAIL single_write we=%b addr=%0d data=%h, required 1 0 %h",
               we_o[0], addr_o[0], data_o[0], word_of(0));
    end
    step();
    checks++;
    if (sta_o[0] !== 1'b1 || ld_o[0] !== 1'b1 || we_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done sta=%b load_done=%b we=%b busy=%b, required 1 1 0 0",
               sta_o[0], ld_o[0], we_o[0], busy_o[0]);
    end
    step();
    checks++;
    if (sta_o[0] !== 1'b1 || ld_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse sta=%b load_done=%b, required 1 0", sta_o[0], ld_o[0]);
    end
    n = 0;
    foreach (wrs[m]) if (wrs[m].inst == 0) n++;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL single_count writes=%0d, required 1", n);
    end
  endtask

  task automatic test_gaps();
    wr_t got[$];
    tx.delete();
    for (int k = 8'h10; k <= 8'h21; k++) tx.push_back(8'(k));
    pulse_start(1);
    send(1, 0, 18, 1'b1);
    step();
    step();
    foreach (wrs[m]) if (wrs[m].inst == 1) got.push_back(wrs[m]);
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL gaps_count writes=%0d, required 2", got.size());
    end
    for (int j = 0; j < 2 && j < got.size(); j++) begin
      checks++;
      if (got[j].a !== 10'(j) || got[j].d !== word_of(j)) begin
        errors++;
        $display("FAIL gaps_word%0d addr=%0d data=%h, required %0d %h", j, got[j].a, got[j].d, j, word_of(j));
      end
    end
    checks++;
    if (sta_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL gaps_sta sta=%b, required 1", sta_o[1]);
    end
  endtask

  task automatic test_full();
    wr_t got[$];
    tx.delete();
    for (int k = 0; k < 9 * FULL_WORDS; k++) tx.push_back(8'($urandom));
    pulse_start(2);
    send(2, 0, 9 * FULL_WORDS, 1'b0);
    step();
    step();
    foreach (wrs[m]) if (wrs[m].inst == 2) got.push_back(wrs[m]);
    checks++;
    if (got.size() != FULL_WORDS) begin
      errors++;
      $display("FAIL full_count writes=%0d, required %0d", got.size(), FULL_WORDS);
    end
    for (int j = 0; j < got.size() && j < FULL_WORDS; j++) begin
      checks++;
      if (got[j].a !== 10'(j) || got[j].d !== word_of(j)) begin
        errors++;
        $display("FAIL full_word%0d addr=%0d data=%h, required %0d %h", j, got[j].a, got[j].d, j, word_of(j));
      end
      if (j > 0) begin
        checks++;
        if (got[j].c - got[j-1].c != 10) begin
          errors++;
          $display("FAIL full_spacing%0d gap=%0d cycles, required 10", j, got[j].c - got[j-1].c);
        end
      end
    end
    if (got.size() > 0) begin
      checks++;
      if (sta_rise[2] != got[got.size()-1].c + 1) begin
        errors++;
        $display("FAIL full_sta_rise at cycle %0d, required %0d", sta_rise[2], got[got.size()-1].c + 1);
      end
    end
    checks++;
    if (addr_o[2] !== 10'(FULL_WORDS - 1) || sta_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL full_hold addr=%0d sta=%b, required %0d 1", addr_o[2], sta_o[2], FULL_WORDS - 1);
    end
  endtask

  task automatic test_restart();
    wr_t got[$];
    tx.delete();
    for (int k = 0; k < 18; k++) tx.push_back(8'($urandom));
    wrs.delete();
    pulse_start(2);
    checks++;
    if (sta_o[2] !== 1'b0 || addr_o[2] !== 10'd0 || busy_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL restart_done sta=%b addr=%0d busy=%b, required 0 0 1", sta_o[2], addr_o[2], busy_o[2]);
    end
    send(2, 0, 4, 1'b0);
    pulse_start(2);
    checks++;
    if (ready_o[2] !== 1'b1 || addr_o[2] !== 10'd0 || busy_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored byte_ready=%b addr=%0d busy=%b, required 1 0 1",
               ready_o[2], addr_o[2], busy_o[2]);
    end
    send(2, 4, 18, 1'b0);
    step();
    foreach (wrs[m]) if (wrs[m].inst == 2) got.push_back(wrs[m]);
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL restart_count writes=%0d, required 2", got.size());
    end
    for (int j = 0; j < 2 && j < got.size(); j++) begin
      checks++;
      if (got[j].a !== 10'(j) || got[j].d !== word_of(j)) begin
        errors++;
        $display("FAIL restart_word%0d addr=%0d data=%h, required %0d %h", j, got[j].a, got[j].d, j, word_of(j));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
    send(2, 18, 22, 1'b0);
    wrs.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o[2], we_o[2], sta_o[2], ld_o[2], busy_o[2]} !== 5'b0 ||
        data_o[2] !== 72'h0 || addr_o[2] !== 10'h0) begin
      errors++;
      $display("FAIL reset_mid rdy/we/sta/ld/busy=%b data=%h addr=%0d, required all 0",
               {ready_o[2], we_o[2], sta_o[2], ld_o[2], busy_o[2]}, data_o[2], addr_o[2]);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy_o[2] !== 1'b0 || ready_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle busy=%b byte_ready=%b, required 0 0", busy_o[2], ready_o[2]);
    end
    tx.delete();
    for (int k = 0; k < 9; k++) tx.push_back(8'($urandom));
    pulse_start(2);
    send(2, 0, 9, 1'b0);
    checks++;
    if (we_o[2] !== 1'b1 || addr_o[2] !== 10'd0 || data_o[2] !== word_of(0)) begin
      errors++;
      $display("FAIL reset_mid_write we=%b addr=%0d data=%h, required 1 0 %h",
               we_o[2], addr_o[2], data_o[2], word_of(0));
    end
    step();
    n = 0;
    foreach (wrs[m]) if (wrs[m].inst == 2) n++;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL reset_mid_count writes=%0d, required 1", n);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      valid_s[i] = 1'b0;
      byte_s[i] = 8'h0;
      sta_rise[i] = -1;
    end
    test_reset();
    test_single();
    test_gaps();
    test_full();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
